rd_tracker: RTL and testbench

RD_TRACKER -- requirements
Module: rd_tracker

---
 rtl/rd_tracker_if.sv | 31 +++
 rtl/rd_tracker.sv | 125 ++++++++++++
 tb/tb_rd_tracker.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rd_tracker_if.sv
// Bundle between the ID stage and the destination-register tracker.
// The master drives the ID-stage instruction fields and the flush request.
// The slave returns the in-flight destinations, the load-use stall and the
// stall statistics counter.
interface rd_tracker_if #(
   parameter int no_of_registers = 32
);
   localparam int RW = $clog2(no_of_registers);

   logic          id_valid;
   logic [6:0]    opcode_id;
   logic [RW-1:0] rd_id;
   logic [RW-1:0] rs1_id;
   logic [RW-1:0] rs2_id;
   logic          flush;
   logic [RW-1:0] rd_pre;
   logic [RW-1:0] rd_pre_pre;
   logic [RW-1:0] rd_pre_pre_pre;
   logic          stall;
   logic [15:0]   stall_count;

   modport master (
      output id_valid, opcode_id, rd_id, rs1_id, rs2_id, flush,
      input  rd_pre, rd_pre_pre, rd_pre_pre_pre, stall, stall_count
   );

   modport slave (
      input  id_valid, opcode_id, rd_id, rs1_id, rs2_id, flush,
      output rd_pre, rd_pre_pre, rd_pre_pre_pre, stall, stall_count
   );
endinterface

// File: rtl/rd_tracker.sv
// Destination-register tracker for a 5-stage in-order pipeline.
// It follows the rd of the instructions in EX, MEM and WB for the forwarding
// unit, and it detects load-use hazards against the EX stage. On a hazard it
// raises a one-cycle stall and injects a bubble into EX. A two-state FSM
// guarantees that the stall never lasts more than one cycle.
module rd_tracker #(
   parameter int no_of_registers = 32
) (
   input logic       clk,
   input logic       rst,
   rd_tracker_if.slave bus
);
   localparam int RW = $clog2(no_of_registers);

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   typedef enum logic {
      RUN    = 1'b0,
      BUBBLE = 1'b1
   } state_t;

   state_t        state_reg;
   state_t        state_next;
   logic [RW-1:0] ex_rd;
   logic [RW-1:0] mem_rd;
   logic [RW-1:0] wb_rd;
   logic          ex_is_load;
   logic [15:0]   stall_count_reg;

   logic [RW-1:0] rd_eff;
   logic          writes_rd;
   logic          uses_rs2;
   logic          hazard;
   logic          stall;
   logic [RW-1:0] src_idx  [2];
   logic [1:0]    src_used;
   logic [1:0]    src_match;

   // Decode which fields of the ID-stage instruction are meaningful.
   always_comb begin
      writes_rd = (bus.opcode_id != OP_STORE) && (bus.opcode_id != OP_BRANCH);
      uses_rs2  = (bus.opcode_id == OP_REG) || (bus.opcode_id == OP_STORE) ||
                  (bus.opcode_id == OP_BRANCH);
      rd_eff    = (bus.id_valid && writes_rd) ? bus.rd_id : '0;
   end

   assign src_idx[0]  = bus.rs1_id;
   assign src_idx[1]  = bus.rs2_id;
   assign src_used[0] = 1'b1;
   assign src_used[1] = uses_rs2;

   // Each source operand is compared against the load destination in EX.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_src
         assign src_match[gi] = src_used[gi] && (src_idx[gi] == ex_rd);
      end
   endgenerate

   // x0 never creates a dependency, so a zero EX destination masks the match.
   assign hazard = bus.id_valid && ex_is_load && (ex_rd != '0) && (|src_match);

   // State register of the FSM.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= RUN;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic: a stall always gets exactly one bubble cycle after it.
   always_comb begin
      state_next = RUN;
      if (state_reg == RUN && stall) begin
         state_next = BUBBLE;
      end
   end

   // Output logic: a flush kills the consumer, so it overrides the hazard.
   always_comb begin
      stall = 1'b0;
      if (state_reg == RUN) begin
         stall = hazard && !bus.flush;
      end
   end

   // Pipeline of destinations. MEM and WB always advance; EX takes a bubble
   // on a stall or a flush.
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_rd      <= '0;
         mem_rd     <= '0;
         wb_rd      <= '0;
         ex_is_load <= 1'b0;
      end else begin
         mem_rd <= ex_rd;
         wb_rd  <= mem_rd;
         if (stall || bus.flush) begin
            ex_rd      <= '0;
            ex_is_load <= 1'b0;
         end else begin
            ex_rd      <= rd_eff;
            ex_is_load <= bus.id_valid && (bus.opcode_id == OP_LOAD);
         end
      end
   end

   // Saturating count of stall cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_count_reg <= '0;
      end else if (stall && stall_count_reg != 16'hFFFF) begin
         stall_count_reg <= stall_count_reg + 16'd1;
      end
   end

   assign bus.rd_pre         = ex_rd;
   assign bus.rd_pre_pre     = mem_rd;
   assign bus.rd_pre_pre_pre = wb_rd;
   assign bus.stall          = stall;
   assign bus.stall_count    = stall_count_reg;
endmodule

// File: tb/tb_rd_tracker.sv
// Bench for rd_tracker. A queue-based model of in-flight destinations is
// checked against the DUT on every cycle. Directed scenarios pin the model
// with literal values. Randomized traffic and a saturation run follow.
module tb_rd_tracker;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   pass_cnt = 0;
   int   total_cnt = 0;
   bit   checking = 1'b0;

   rd_tracker_if #(.no_of_registers(32)) bus ();

   rd_tracker #(.no_of_registers(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Model state. m_dest[0] is EX, m_dest[1] is MEM and m_dest[2] is WB.
   logic [4:0]  m_dest[$];
   bit          m_ex_load;
   bit          m_last_stall;
   logic [15:0] m_count;

   function automatic bit reads_rs2(input logic [6:0] op);
      return op inside {OP_REG, OP_STORE, OP_BRANCH};
   endfunction

   function automatic bit model_stall();
      if (m_last_stall || !bus.id_valid || !m_ex_load || bus.flush) return 1'b0;
      if (m_dest[0] == 5'd0) return 1'b0;
      return (bus.rs1_id == m_dest[0]) ||
             (reads_rs2(bus.opcode_id) && bus.rs2_id == m_dest[0]);
   endfunction

   // Model update on each rising edge. Inputs are stable, because the
   // driver changes them 1 time unit after the edge.
   initial begin
      m_dest = '{5'd0, 5'd0, 5'd0};
      m_ex_load = 1'b0;
      m_last_stall = 1'b0;
      m_count = 16'd0;
      forever begin
         bit s;
         bit kill;
         logic [4:0] nd;
         @(posedge clk);
         if (rst) begin
            m_dest = '{5'd0, 5'd0, 5'd0};
            m_ex_load = 1'b0;
            m_last_stall = 1'b0;
            m_count = 16'd0;
         end else begin
            s = model_stall();
            kill = s || bus.flush;
            nd = (!kill && bus.id_valid && !(bus.opcode_id inside {OP_STORE, OP_BRANCH}))
                 ? bus.rd_id : 5'd0;
            m_dest.push_front(nd);
            void'(m_dest.pop_back());
            m_ex_load = !kill && bus.id_valid && bus.opcode_id == OP_LOAD;
            m_last_stall = s;
            if (s && m_count != 16'hFFFF) m_count = m_count + 16'd1;
         end
         checking = 1'b1;
      end
   end

   // One compare per cycle, taken mid-cycle on the falling edge.
   initial begin
      forever begin
         bit es;
         @(negedge clk);
         if (checking) begin
            es = model_stall();
            total_cnt++;
            if (bus.rd_pre === m_dest[0] && bus.rd_pre_pre === m_dest[1] &&
                bus.rd_pre_pre_pre === m_dest[2] && bus.stall === es &&
                bus.stall_count === m_count) begin
               pass_cnt++;
            end else begin
               $display("FAIL cycle_model t=%0t got pre=%0d/%0d/%0d stall=%0b cnt=%0d want pre=%0d/%0d/%0d stall=%0b cnt=%0d",
                        $time, bus.rd_pre, bus.rd_pre_pre, bus.rd_pre_pre_pre, bus.stall,
                        bus.stall_count, m_dest[0], m_dest[1], m_dest[2], es, m_count);
            end
         end
      end
   end

   task automatic check_lit(input string name, input int act, input int exp);
      total_cnt++;
      if (act == exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s got=%0d want=%0d", name, act, exp);
      end
   endtask

   task automatic drive(input bit v, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input bit fl);
      bus.id_valid  = v;
      bus.opcode_id = op;
      bus.rd_id     = rd;
      bus.rs1_id    = rs1;
      bus.rs2_id    = rs2;
      bus.flush     = fl;
   endtask

   task automatic drive_random();
      drive(1'(($urandom)), 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom));
   endtask

   // Present one ID-stage instruction for the next clock edge, then settle.
   task automatic step(input bit v, input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input bit fl);
      @(posedge clk);
      #1;
      drive(v, op, rd, rs1, rs2, fl);
      #1;
   endtask

   task automatic idle();
      step(1'b0, OP_IMM, 5'd0, 5'd0, 5'd0, 1'b0);
   endtask

   // Hold rst for two edges with random inputs, then release it with ID empty.
   task automatic do_reset(input bit check);
      @(posedge clk);
      #1;
      rst = 1'b1;
      drive_random();
      repeat (2) begin
         @(posedge clk);
         #1;
         drive_random();
      end
      #1;
      if (check) begin
         check_lit("reset_rd_pre", 32'(bus.rd_pre), 0);
         check_lit("reset_rd_pre_pre", 32'(bus.rd_pre_pre), 0);
         check_lit("reset_rd_pre_pre_pre", 32'(bus.rd_pre_pre_pre), 0);
         check_lit("reset_stall", 32'(bus.stall), 0);
         check_lit("reset_stall_count", 32'(bus.stall_count), 0);
      end
      rst = 1'b0;
      drive(1'b0, OP_IMM, 5'd0, 5'd0, 5'd0, 1'b0);
   endtask

   initial begin
      logic [6:0] ops [7];
      logic [6:0] op;
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
      bit         v;
      ops = '{OP_LOAD, OP_STORE, OP_BRANCH, OP_REG, OP_IMM, OP_LUI, OP_JAL};
      drive(1'b0, OP_IMM, 5'd0, 5'd0, 5'd0, 1'b0);

      do_reset(1'b1);

      // Destinations shift through EX, MEM and WB.
      step(1'b1, OP_IMM, 5'd5, 5'd1, 5'd0, 1'b0);
      step(1'b1, OP_IMM, 5'd6, 5'd1, 5'd0, 1'b0);
      step(1'b1, OP_IMM, 5'd7, 5'd1, 5'd0, 1'b0);
      idle();
      check_lit("shift_rd_pre", 32'(bus.rd_pre), 7);
      check_lit("shift_rd_pre_pre", 32'(bus.rd_pre_pre), 6);
      check_lit("shift_rd_pre_pre_pre", 32'(bus.rd_pre_pre_pre), 5);

      // A load followed by a dependent add stalls for one cycle and inserts a bubble.
      do_reset(1'b0);
      step(1'b1, OP_LOAD, 5'd3, 5'd1, 5'd0, 1'b0);
      step(1'b1, OP_REG, 5'd10, 5'd0, 5'd3, 1'b0);
      check_lit("loaduse_stall", 32'(bus.stall), 1);
      step(1'b1, OP_REG, 5'd10, 5'd0, 5'd3, 1'b0);
      check_lit("loaduse_stall_once", 32'(bus.stall), 0);
      check_lit("loaduse_bubble", 32'(bus.rd_pre), 0);
      check_lit("loaduse_mem", 32'(bus.rd_pre_pre), 3);
      check_lit("loaduse_count", 32'(bus.stall_count), 1);
      idle();

      // A store does not write rd, but a store that consumes a load does stall.
      step(1'b1, OP_STORE, 5'd9, 5'd1, 5'd2, 1'b0);
      idle();
      check_lit("store_rd_pre", 32'(bus.rd_pre), 0);
      step(1'b1, OP_LOAD, 5'd4, 5'd1, 5'd0, 1'b0);
      step(1'b1, OP_STORE, 5'd0, 5'd0, 5'd4, 1'b0);
      check_lit("store_rs2_stall", 32'(bus.stall), 1);
      step(1'b1, OP_STORE, 5'd0, 5'd0, 5'd4, 1'b0);
      idle();

      // A flush overrides the hazard and kills the consumer.
      step(1'b1, OP_LOAD, 5'd2, 5'd1, 5'd0, 1'b0);
      step(1'b1, OP_IMM, 5'd11, 5'd2, 5'd0, 1'b1);
      check_lit("flush_stall", 32'(bus.stall), 0);
      idle();
      check_lit("flush_rd_pre", 32'(bus.rd_pre), 0);

      // With back-to-back dependent loads, the second load still counts as a load in EX.
      step(1'b1, OP_LOAD, 5'd3, 5'd1, 5'd0, 1'b0);
      step(1'b1, OP_LOAD, 5'd8, 5'd3, 5'd0, 1'b0);
      check_lit("b2b_stall", 32'(bus.stall), 1);
      step(1'b1, OP_LOAD, 5'd8, 5'd3, 5'd0, 1'b0);
      step(1'b1, OP_IMM, 5'd12, 5'd8, 5'd0, 1'b0);
      check_lit("b2b_ex_rd", 32'(bus.rd_pre), 8);
      check_lit("b2b_second_stall", 32'(bus.stall), 1);
      step(1'b1, OP_IMM, 5'd12, 5'd8, 5'd0, 1'b0);
      idle();

      // A load with rd=x0 never causes a hazard.
      step(1'b1, OP_LOAD, 5'd0, 5'd1, 5'd0, 1'b0);
      step(1'b1, OP_REG, 5'd13, 5'd0, 5'd0, 1'b0);
      check_lit("x0_no_stall", 32'(bus.stall), 0);

      // A reset during a stall leaves no bubble pending.
      step(1'b1, OP_LOAD, 5'd5, 5'd1, 5'd0, 1'b0);
      step(1'b1, OP_REG, 5'd1, 5'd5, 5'd0, 1'b0);
      check_lit("midrst_stall", 32'(bus.stall), 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check_lit("midrst_stall_cleared", 32'(bus.stall), 0);
      check_lit("midrst_rd_pre_pre", 32'(bus.rd_pre_pre), 0);
      check_lit("midrst_count", 32'(bus.stall_count), 0);
      step(1'b1, OP_LOAD, 5'd6, 5'd1, 5'd0, 1'b0);
      check_lit("midrst_resume_ex", 32'(bus.rd_pre), 1);

      // Random traffic with a small register range, so that dependencies are frequent.
      op = OP_IMM; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; v = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk);
         #1;
         rst = ($urandom_range(0, 63) == 0);
         if (!bus.stall) begin
            v   = ($urandom_range(0, 9) < 8);
            op  = ops[$urandom_range(0, 6)];
            rd  = 5'($urandom_range(0, 7));
            rs1 = 5'($urandom_range(0, 7));
            rs2 = 5'($urandom_range(0, 7));
         end
         drive(v, op, rd, rs1, rs2, ($urandom_range(0, 9) == 0));
      end
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Saturation: a self-dependent load held in ID stalls on every other cycle.
      do_reset(1'b0);
      step(1'b1, OP_LOAD, 5'd3, 5'd3, 5'd0, 1'b0);
      repeat (131082) @(posedge clk);
      #2;
      check_lit("saturate_count", 32'(bus.stall_count), 32'hFFFF);
      repeat (4) @(posedge clk);
      #2;
      check_lit("saturate_hold", 32'(bus.stall_count), 32'hFFFF);

      idle();
      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
